// File: rtl/sqrt_param.sv
// rtl/sqrt_param.sv - iterative restoring unsigned square root, one root bit per cycle
module sqrt_param #(
    parameter int WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               round_i,
    input  logic [WIDTH-1:0]   x_bi,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH/2-1:0] y_bo,
    output logic [WIDTH/2:0]   rem_bo
);
    localparam int R  = WIDTH / 2;
    localparam int CW = (R > 2) ? $clog2(R) : 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] x_q;
    logic           round_q;
    logic [R-1:0]   root_q;
    logic [R+1:0]   rem_q;

    logic [R+3:0]   acc;
    logic [R+3:0]   diff;
    logic [R+1:0]   rem_n;
    logic [R-1:0]   root_n;
    logic           round_up;
    logic [R-1:0]   y_final;
    logic           step_unused;

    // One restoring digit step: bring down the next radicand pair, try subtracting 4*root+1.
    always_comb begin
        acc  = {rem_q, x_q[WIDTH-1 -: 2]};
        diff = acc - {2'b00, root_q, 2'b01};
        if (!diff[R+3]) begin
            rem_n  = diff[R+1:0];
            root_n = {root_q[R-2:0], 1'b1};
        end else begin
            rem_n  = acc[R+1:0];
            root_n = {root_q[R-2:0], 1'b0};
        end
        round_up = round_q && (rem_n > {2'b00, root_n});
        // f+1 only overflows when f is all-ones; saturate instead of wrapping to zero.
        if (round_up && !(&root_n))
            y_final = root_n + 1'b1;
        else
            y_final = root_n;
    end

    assign step_unused = ^{acc[R+3:R+2], diff[R+2]};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            cnt     <= '0;
            x_q     <= '0;
            round_q <= 1'b0;
            root_q  <= '0;
            rem_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            y_bo    <= '0;
            rem_bo  <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        x_q     <= x_bi;
                        round_q <= round_i;
                        root_q  <= '0;
                        rem_q   <= '0;
                        cnt     <= CW'(R - 1);
                        state   <= CALC;
                        busy_o  <= 1'b1;
                    end
                end
                CALC: begin
                    x_q    <= x_q << 2;
                    root_q <= root_n;
                    rem_q  <= rem_n;
                    if (cnt == '0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        y_bo   <= y_final;
                        rem_bo <= rem_n[R:0];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
